// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - default parameters and helpers for the prescale clock divider
package clk_div_pkg;

  localparam int DEF_PRESC_W   = 6;
  localparam int DEF_RATIO_W   = 8;
  localparam int DEF_BASE_OS   = 32;
  localparam int DEF_MIN_PRESC = 4;

  function automatic logic is_pow2(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/prescale_ratio_decode.sv
// rtl/prescale_ratio_decode.sv - maps a power-of-two prescale to division ratio BASE_OS/prescale
module prescale_ratio_decode
  import clk_div_pkg::*;
#(
  parameter int PRESC_W   = DEF_PRESC_W,
  parameter int RATIO_W   = DEF_RATIO_W,
  parameter int BASE_OS   = DEF_BASE_OS,
  parameter int MIN_PRESC = DEF_MIN_PRESC
) (
  input  logic [PRESC_W-1:0] prescale,
  output logic [RATIO_W-1:0] dec_ratio,
  output logic               legal
);

  logic [RATIO_W-1:0] shifted;

  // Only one bit can match once the value is known to be a power of two.
  always_comb begin
    shifted = RATIO_W'(1);
    for (int k = 0; k < PRESC_W; k++) begin
      if (32'(prescale) == (32'd1 << k))
        shifted = RATIO_W'(BASE_OS >> k);
    end
  end

  always_comb begin
    legal = is_pow2(32'(prescale)) &&
            (32'(prescale) >= 32'(MIN_PRESC)) &&
            (32'(prescale) <= 32'(BASE_OS));
    dec_ratio = legal ? shifted : RATIO_W'(1);
  end

endmodule

// File: rtl/prescale_clk_div.sv
// rtl/prescale_clk_div.sv - prescale-driven divider for the UART RX oversampling clock
// Optional tick output built only when PRESC_DIV_TICK_EN is defined.
module prescale_clk_div
  import clk_div_pkg::*;
#(
  parameter int PRESC_W   = DEF_PRESC_W,
  parameter int RATIO_W   = DEF_RATIO_W,
  parameter int BASE_OS   = DEF_BASE_OS,
  parameter int MIN_PRESC = DEF_MIN_PRESC
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_div_clk,
  output logic [RATIO_W-1:0] o_ratio,
  output logic               o_cfg_err,
  output logic               o_div_tick
);

  logic [RATIO_W-1:0] dec_ratio;
  logic               legal;
  logic [RATIO_W-1:0] r_req;
  logic [RATIO_W-1:0] r_act;
  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] next_r;
  logic [RATIO_W-1:0] next_cnt;
  logic [RATIO_W:0]   next_half;
  logic               last_cnt;
  logic               upd;
  logic               en_q;
  logic               div_q;

  prescale_ratio_decode #(
    .PRESC_W  (PRESC_W),
    .RATIO_W  (RATIO_W),
    .BASE_OS  (BASE_OS),
    .MIN_PRESC(MIN_PRESC)
  ) u_decode (
    .prescale (i_prescale),
    .dec_ratio(dec_ratio),
    .legal    (legal)
  );

  // The first enabled edge parks cnt at 0 so the output opens with a full high phase.
  always_comb begin
    last_cnt  = (cnt == r_act - RATIO_W'(1));
    upd       = last_cnt || !i_clk_en || (r_act == RATIO_W'(1));
    next_r    = upd ? r_req : r_act;
    next_cnt  = (!i_clk_en || !en_q || last_cnt) ? '0 : cnt + RATIO_W'(1);
    next_half = ({1'b0, next_r} + (RATIO_W+1)'(1)) >> 1;
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_req     <= RATIO_W'(1);
      r_act     <= RATIO_W'(1);
      cnt       <= '0;
      en_q      <= 1'b0;
      div_q     <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      r_req     <= dec_ratio;
      r_act     <= next_r;
      cnt       <= next_cnt;
      en_q      <= i_clk_en;
      div_q     <= i_clk_en && (next_r >= RATIO_W'(2)) &&
                   ({1'b0, next_cnt} < next_half);
      o_cfg_err <= ~legal;
    end
  end

  // R = 1 passes the reference clock straight through, gated by the registered enable.
  assign o_div_clk = (r_act == RATIO_W'(1)) ? (i_ref_clk & en_q) : div_q;
  assign o_ratio   = r_act;

`ifdef PRESC_DIV_TICK_EN
  always_ff @(posedge i_ref_clk) begin
    if (i_rst)
      o_div_tick <= 1'b0;
    else
      o_div_tick <= i_clk_en && (next_cnt == '0);
  end
`else
  assign o_div_tick = 1'b0;
`endif

endmodule

// File: tb/tb_prescale_clk_div.sv
// tb/tb_prescale_clk_div.sv - self-checking bench for prescale_clk_div
module tb_prescale_clk_div;

  typedef struct {
    logic [5:0] presc;
    int         ratio;
    int         hi;
    int         lo;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] presc;
  logic       div_clk;
  logic [7:0] ratio;
  logic       cfg_err;
  logic       div_tick;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[8];
  vec_t exp_q[$];

  prescale_clk_div dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .i_clk_en  (en),
    .i_prescale(presc),
    .o_div_clk (div_clk),
    .o_ratio   (ratio),
    .o_cfg_err (cfg_err),
    .o_div_tick(div_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    @(negedge clk);
    prev = div_clk;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (!prev && div_clk) ok = 1'b1;
      prev = div_clk;
    end
  endtask

  task automatic measure_period(output int hi, output int lo, output bit ok);
    bit found;
    hi = 0;
    lo = 0;
    sync_rise(found);
    ok = found;
    if (found) begin
      hi = 1;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (div_clk && lo == 0) hi++;
        else if (!div_clk) lo++;
        else break;
      end
    end
  endtask

  task automatic bypass_errors(output int errs);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (div_clk !== 1'b0) errs++;
      @(posedge clk);
      #1;
      if (div_clk !== 1'b1) errs++;
    end
  endtask

  task automatic collect(input int n, output logic [7:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits = {bits[6:0], div_clk};
    end
  endtask

  initial begin
    vec_t       e;
    int         hi, lo, errs, ticks, misaligned;
    bit         ok;
    logic [7:0] bits;

    vecs[0] = '{presc: 6'd32, ratio: 1, hi: 0, lo: 0, err: 1'b0};
    vecs[1] = '{presc: 6'd8,  ratio: 4, hi: 2, lo: 2, err: 1'b0};
    vecs[2] = '{presc: 6'd4,  ratio: 8, hi: 4, lo: 4, err: 1'b0};
    vecs[3] = '{presc: 6'd16, ratio: 2, hi: 1, lo: 1, err: 1'b0};
    vecs[4] = '{presc: 6'd12, ratio: 1, hi: 0, lo: 0, err: 1'b1};
    vecs[5] = '{presc: 6'd2,  ratio: 1, hi: 0, lo: 0, err: 1'b1};
    vecs[6] = '{presc: 6'd0,  ratio: 1, hi: 0, lo: 0, err: 1'b1};
    vecs[7] = '{presc: 6'd8,  ratio: 4, hi: 2, lo: 2, err: 1'b0};

    rst   = 1'b1;
    en    = 1'b1;
    presc = 6'd32;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ratio", int'(ratio), 1);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_tick", int'(div_tick), 0);
    check("reset_div_low", int'(div_clk), 0);
    @(posedge clk);
    #1;
    check("reset_div_high_ref", int'(div_clk), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      presc = vecs[v].presc;
      exp_q.push_back(vecs[v]);
      @(negedge clk);
      check($sformatf("v%0d_cfg_err", v), int'(cfg_err), int'(vecs[v].err));
      repeat (20) @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_ratio", v), int'(ratio), e.ratio);
      if (e.ratio == 1) begin
        bypass_errors(errs);
        check($sformatf("v%0d_bypass_errs", v), errs, 0);
      end else begin
        measure_period(hi, lo, ok);
        check($sformatf("v%0d_found", v), int'(ok), 1);
        check($sformatf("v%0d_high", v), hi, e.hi);
        check($sformatf("v%0d_low", v), lo, e.lo);
      end
    end

    // Odd ratio via forced request register
    force dut.r_req = 8'd5;
    repeat (20) @(negedge clk);
    check("odd_ratio", int'(ratio), 5);
    measure_period(hi, lo, ok);
    check("odd_high", hi, 3);
    check("odd_low", lo, 2);
    release dut.r_req;
    repeat (12) @(negedge clk);
    check("odd_release_ratio", int'(ratio), 4);

    // Ratio change mid-period: R=8 finishes, then R=2
    presc = 6'd4;
    repeat (20) @(negedge clk);
    sync_rise(ok);
    check("chg_sync", int'(ok), 1);
    repeat (3) @(negedge clk);
    presc = 6'd16;
    collect(8, bits);
    check("chg_sequence", int'(bits), int'(8'b0000_1010));
    check("chg_ratio", int'(ratio), 2);

    // Enable drop and restart at R=4
    presc = 6'd8;
    repeat (20) @(negedge clk);
    sync_rise(ok);
    en = 1'b0;
    @(negedge clk);
    check("dis_div_next", int'(div_clk), 0);
    repeat (3) @(negedge clk);
    check("dis_div_hold", int'(div_clk), 0);
    en = 1'b1;
    collect(4, bits);
    check("reen_sequence", int'(bits[3:0]), int'(4'b1100));

    // Bypass forced low while disabled
    @(negedge clk);
    en    = 1'b0;
    presc = 6'd32;
    repeat (4) @(negedge clk);
    check("dis_bypass_ratio", int'(ratio), 1);
    @(posedge clk);
    #1;
    check("dis_bypass_div", int'(div_clk), 0);

    // Tick count and alignment at R=4
    @(negedge clk);
    en    = 1'b1;
    presc = 6'd8;
    repeat (20) @(negedge clk);
    ticks      = 0;
    misaligned = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (div_tick) begin
        ticks++;
        if (!div_clk) misaligned++;
      end
    end
`ifdef PRESC_DIV_TICK_EN
    check("tick_count", ticks, 4);
`else
    check("tick_count", ticks, 0);
`endif
    check("tick_misaligned", misaligned, 0);

    // Reset mid-period
    sync_rise(ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ratio", int'(ratio), 1);
    check("midrst_div", int'(div_clk), 0);
    check("midrst_err", int'(cfg_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
